// File: rtl/dino_game_ctrl.sv
// Game-sequencing controller for the dino VGA game: restart handshake, start countdown,
// pause/halt gating, collision-to-game-over and high-score tracking.
module dino_game_ctrl #(
    parameter int unsigned START_TIME = 30000000,
    parameter int unsigned REARM_TIME = 100000,
    parameter int unsigned BLINK_BIT  = 22,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               jump_in,
    input  logic               halt_in,
    input  logic               debug_in,
    input  logic               collision,
    input  logic [SCORE_W-1:0] score_in,
    output logic               game_rst,
    output logic               game_halt,
    output logic               game_over,
    output logic               start_blink,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic [1:0]         state
);

    localparam int unsigned REARM_W =
        ($clog2(REARM_TIME + 1) > 20) ? $clog2(REARM_TIME + 1) : 20;
    localparam logic [REARM_W-1:0] REARM_MAX  = REARM_W'(REARM_TIME);
    localparam logic [31:0]        START_LAST = 32'(START_TIME - 1);

    typedef enum logic [1:0] {
        StOver      = 2'd0,
        StCountdown = 2'd1,
        StRun       = 2'd2,
        StUnused    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          start_ctr_q, start_ctr_d;
    logic [REARM_W-1:0]   rearm_ctr_q, rearm_ctr_d;
    logic [SCORE_W-1:0]   high_score_q, high_score_d;
    logic                 new_high_q, new_high_d;
    logic                 game_rst_q, game_rst_d;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q      <= StOver;
            start_ctr_q  <= '0;
            rearm_ctr_q  <= '0;
            high_score_q <= '0;
            new_high_q   <= 1'b0;
            game_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_ctr_q  <= start_ctr_d;
            rearm_ctr_q  <= rearm_ctr_d;
            high_score_q <= high_score_d;
            new_high_q   <= new_high_d;
            game_rst_q   <= game_rst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_ctr_d  = start_ctr_q;
        high_score_d = high_score_q;
        new_high_d   = new_high_q;
        game_rst_d   = 1'b0;

        // Idle-time counter: a restart needs the button released long enough first.
        if (jump_in) begin
            rearm_ctr_d = '0;
        end else if (rearm_ctr_q >= REARM_MAX) begin
            rearm_ctr_d = rearm_ctr_q;
        end else begin
            rearm_ctr_d = rearm_ctr_q + REARM_W'(1);
        end

        case (state_q)
            StOver: begin
                if (jump_in && (rearm_ctr_q >= REARM_MAX)) begin
                    state_d     = StCountdown;
                    start_ctr_d = '0;
                    game_rst_d  = 1'b1;
                    new_high_d  = 1'b0;
                end
            end
            StCountdown: begin
                if (!halt_in) begin
                    start_ctr_d = start_ctr_q + 32'd1;
                    if (start_ctr_q == START_LAST) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (collision && !debug_in && !halt_in) begin
                    state_d = StOver;
                    if (score_in > high_score_q) begin
                        high_score_d = score_in;
                        new_high_d   = 1'b1;
                    end
                end
            end
            default: state_d = StOver;
        endcase
    end

    // The unused encoding behaves like OVER until it recovers on the next edge.
    assign game_over   = (state_q != StRun) && (state_q != StCountdown);
    assign game_halt   = (state_q != StRun) || halt_in;
    assign start_blink = (state_q == StCountdown) ? start_ctr_q[BLINK_BIT] : 1'b1;
    assign game_rst    = game_rst_q;
    assign high_score  = high_score_q;
    assign new_high    = new_high_q;
    assign state       = state_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Bench for dino_game_ctrl: directed test-plan steps followed by random play, all checked
// each cycle against a game-level reference model.
module tb_dino_game_ctrl;

    localparam int unsigned START_TIME = 16;
    localparam int unsigned REARM_TIME = 4;
    localparam int unsigned BLINK_BIT  = 2;
    localparam int unsigned SCORE_W    = 16;

    logic               clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic               jump_in = 1'b0;
    logic               halt_in = 1'b0;
    logic               debug_in = 1'b0;
    logic               collision = 1'b0;
    logic [SCORE_W-1:0] score_in = '0;
    logic               game_rst;
    logic               game_halt;
    logic               game_over;
    logic               start_blink;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;
    logic [1:0]         state;

    int vectors = 0;
    int miscompares = 0;

    // Model: game phase, unhalted countdown cycles elapsed, button idle time, scores.
    int m_phase = 0;   // 0 = game over, 1 = counting down, 2 = running
    int m_elapsed = 0;
    int m_idle = 0;
    int m_best = 0;
    bit m_new = 1'b0;
    bit m_pulse = 1'b0;

    dino_game_ctrl #(
        .START_TIME(START_TIME),
        .REARM_TIME(REARM_TIME),
        .BLINK_BIT (BLINK_BIT),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .jump_in    (jump_in),
        .halt_in    (halt_in),
        .debug_in   (debug_in),
        .collision  (collision),
        .score_in   (score_in),
        .game_rst   (game_rst),
        .game_halt  (game_halt),
        .game_over  (game_over),
        .start_blink(start_blink),
        .high_score (high_score),
        .new_high   (new_high),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int blink_phase;
        blink_phase = (m_elapsed / (1 << BLINK_BIT)) % 2;
        check("state", 32'(state), 32'(m_phase));
        check("game_over", 32'(game_over), 32'(m_phase == 0));
        check("game_halt", 32'(game_halt), 32'((m_phase != 2) || halt_in));
        check("start_blink", 32'(start_blink), 32'((m_phase == 1) ? blink_phase : 1));
        check("game_rst", 32'(game_rst), 32'(m_pulse));
        check("high_score", 32'(high_score), 32'(m_best));
        check("new_high", 32'(new_high), 32'(m_new));
    endtask

    task automatic model_step();
        bit pulse;
        pulse = 1'b0;
        if (sys_rst) begin
            m_phase = 0; m_elapsed = 0; m_idle = 0; m_best = 0; m_new = 1'b0;
            m_pulse = 1'b0;
            return;
        end
        if (m_phase == 0) begin
            if (jump_in && m_idle >= int'(REARM_TIME)) begin
                m_phase = 1; m_elapsed = 0; pulse = 1'b1; m_new = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (!halt_in) begin
                m_elapsed++;
                if (m_elapsed == int'(START_TIME)) m_phase = 2;
            end
        end else begin
            if (collision && !debug_in && !halt_in) begin
                m_phase = 0;
                if (int'(score_in) > m_best) begin
                    m_best = int'(score_in);
                    m_new = 1'b1;
                end
            end
        end
        m_idle = jump_in ? 0 : ((m_idle >= int'(REARM_TIME)) ? m_idle : m_idle + 1);
        m_pulse = pulse;
    endtask

    // Check outputs for the current inputs, then advance one clock.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            #1;
            check_outputs();
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic restart_and_run();
        jump_in = 1'b0; tick(int'(REARM_TIME));
        jump_in = 1'b1; tick();
        jump_in = 1'b0; tick(int'(START_TIME));
    endtask

    initial begin
        @(posedge clk);
        #1;
        sys_rst = 1'b1; tick(2);
        sys_rst = 1'b0;

        // Idle then jump: countdown then run.
        jump_in = 1'b0; tick(5);
        jump_in = 1'b1; tick();
        jump_in = 1'b0;
        check("plan1_rst_pulse", 32'(game_rst), 32'd1);
        check("plan1_countdown", 32'(state), 32'd1);
        tick(int'(START_TIME));
        check("plan1_run", 32'(state), 32'd2);
        tick(3);

        // Death with a new high score.
        score_in = 16'd37; collision = 1'b1; tick();
        collision = 1'b0;
        check("plan4_over", 32'(state), 32'd0);
        check("plan4_high", 32'(high_score), 32'd37);
        check("plan4_new", 32'(new_high), 32'd1);
        tick(2);

        // Held jump and short releases never restart.
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        jump_in = 1'b1; tick(20);
        jump_in = 1'b0; tick(3);
        jump_in = 1'b1; tick();
        check("plan2_no_restart", 32'(state), 32'd0);
        jump_in = 1'b0; tick(4);
        jump_in = 1'b1; tick();
        jump_in = 1'b0;
        check("plan2_restart", 32'(state), 32'd1);

        // Pause the countdown at 5 unhalted cycles.
        tick(5);
        halt_in = 1'b1; tick(10);
        halt_in = 1'b0;
        check("plan3_still_cd", 32'(state), 32'd1);
        tick(int'(START_TIME) - 5);
        check("plan3_run", 32'(state), 32'd2);

        // Collisions masked by debug and by halt.
        score_in = 16'd50;
        collision = 1'b1; debug_in = 1'b1; tick(3);
        debug_in = 1'b0; halt_in = 1'b1; tick(3);
        check("plan5_halt", 32'(game_halt), 32'd1);
        collision = 1'b0; halt_in = 1'b0; tick();
        check("plan5_alive", 32'(state), 32'd2);

        // Score equal to best: no update.
        score_in = 16'd0; collision = 1'b1; tick(); collision = 1'b0;
        restart_and_run();
        score_in = 16'd37; collision = 1'b1; tick(); collision = 1'b0;
        restart_and_run();
        score_in = 16'd37; collision = 1'b1; tick(); collision = 1'b0;
        check("plan4_equal_new", 32'(new_high), 32'd0);

        // Reset mid-run wipes the high score.
        restart_and_run();
        score_in = 16'd90; tick(2);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        check("plan6_state", 32'(state), 32'd0);
        check("plan6_high", 32'(high_score), 32'd0);
        check("plan6_over", 32'(game_over), 32'd1);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            jump_in   = ($urandom_range(0, 7) == 0);
            halt_in   = ($urandom_range(0, 7) == 0);
            debug_in  = ($urandom_range(0, 7) == 0);
            collision = ($urandom_range(0, 15) == 0);
            sys_rst   = ($urandom_range(0, 399) == 0);
            score_in  = SCORE_W'($urandom_range(0, 1000));
            tick();
        end
        sys_rst = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
- Central game-sequencing FSM for the dino VGA game.
- Owns the restart handshake, the start countdown, the pause and halt gating, collision-to-game-over handling, and high-score tracking.
- Drives the shared `game_rst` and `game_halt` strobes consumed by the jumping, scroll, dinosprite and score blocks, and the `start_blink` / `game_over` inputs of the renderer.
- Replaces the ad-hoc top-level game-state logic with a single registered controller.

Parameters:
- `START_TIME`, default 30000000: countdown length in cycles from restart to RUN.
- `REARM_TIME`, default 100000: consecutive `jump_in`-low cycles required before a restart jump is accepted.
- `BLINK_BIT`, default 22: bit of the countdown counter that drives `start_blink` during COUNTDOWN.
- `SCORE_W`, default 16: score and high-score width.

Ports:
- `clk`  in  1  system clock.
- `sys_rst`  in  1  synchronous active-high reset.
- `jump_in`  in  1  player jump button, level, already synchronised.
- `halt_in`  in  1  external pause request, level.
- `debug_in`  in  1  invulnerability; collisions are ignored while high.
- `collision`  in  1  renderer collision flag.
- `score_in`  in  `SCORE_W`  current score from the score block.
- `game_rst`  out  1  one-cycle restart pulse to datapath blocks.
- `game_halt`  out  1  freeze for all game datapath blocks.
- `game_over`  out  1  high while state is OVER.
- `start_blink`  out  1  renderer dino-visibility blink.
- `high_score`  out  `SCORE_W`  best score since `sys_rst`.
- `new_high`  out  1  last game set a new high score.
- `state`  out  2  encoding: OVER=0, COUNTDOWN=1, RUN=2; 3 is unused.

Behaviour:
- Reset: one clock, reset synchronous active-high, named `clk` and `sys_rst`. While `sys_rst` is high:
  - `state`=OVER, `start_ctr`=0, `rearm_ctr`=0.
  - `high_score`=0, `new_high`=0, `game_rst`=0.
  - Hence `game_over`=1, `game_halt`=1, `start_blink`=1.
  - `sys_rst` dominates every other event, including mid-countdown and mid-run.
- `rearm_ctr`:
  - 20 bits minimum, large enough to hold `REARM_TIME`.
  - Runs in all states.
  - Cleared in any cycle `jump_in`=1; otherwise increments, saturating at `REARM_TIME`.
- OVER state:
  - Restart is accepted when `jump_in`=1 and registered `rearm_ctr` >= `REARM_TIME` in the same cycle.
  - On accept, the next edge sets `state`=COUNTDOWN, `start_ctr`=0 and `game_rst`=1.
  - `game_rst` is therefore high exactly in the first COUNTDOWN cycle and low in every other cycle.
  - `new_high` clears on that same edge.
  - A jump held through the death, or with fewer than `REARM_TIME` idle cycles, never restarts.
- COUNTDOWN state:
  - `start_ctr` (32 bits) increments each cycle that `halt_in`=0 and holds while `halt_in`=1.
  - When `start_ctr` == `START_TIME`-1 and `halt_in`=0, the next state is RUN.
  - `collision` and `jump_in` are ignored for state transitions.
- RUN state:
  - If `collision`=1, `debug_in`=0 and `halt_in`=0, the next state is OVER.
  - On that same edge, if `score_in` > `high_score` (unsigned), `high_score`<=`score_in` and `new_high`<=1.
  - A score equal to `high_score` does not update and does not set `new_high`.
  - With `debug_in`=1, the game never ends.
- Outputs, combinational from registers:
  - `game_halt` = (`state`!=RUN) | `halt_in`.
  - `game_over` = (`state`==OVER).
  - `start_blink` = 1 in OVER and RUN; `start_ctr`[`BLINK_BIT`] in COUNTDOWN.
- Unused state 3 recovers to OVER on the next edge, with outputs as OVER.

Test Plan (`START_TIME`=16, `REARM_TIME`=4, `BLINK_BIT`=2):
1. Reset, then `jump_in` low 5 cycles, then high 1 cycle:
   - `game_rst` is high exactly 1 cycle after the jump edge.
   - `state` goes 0→1.
   - `state`=2 exactly 16 unhalted cycles later.
   - `game_halt` drops in the same cycle `state`=2.
2. Reset, then `jump_in` held high 20 cycles:
   - No `game_rst`; `state` stays 0.
   - Release 3 cycles then press: still no restart.
   - Release 4 cycles then press: restart.
3. COUNTDOWN with `halt_in`=1 for 10 cycles at `start_ctr`=5:
   - `start_ctr` holds at 5.
   - RUN is reached after 16 unhalted cycles total.
   - `start_blink` toggles every 4 unhalted cycles.
4. RUN, `score_in`=37, `high_score`=0, `collision` pulse:
   - Next cycle `state`=0, `high_score`=37, `new_high`=1.
   - Repeat the game with `score_in`=37: `high_score` stays 37 and `new_high` stays 0 after the restart clears it.
5. RUN, collision with `debug_in`=1 or `halt_in`=1:
   - `state` stays 2; `high_score` is unchanged.
   - With `halt_in`=1, `game_halt`=1.
6. `sys_rst` asserted mid-RUN with `high_score`=37:
   - Next cycle `state`=0, `high_score`=0, `game_over`=1, `game_rst`=0.
